// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one external 32x32 signed multiplier between two requesters.
// Latency: rsp_valid rises MUL_LAT edges after accept; backpressure: result held until rsp_ready, no accept until then.
// Optional macro MULT_ARB_HILO_EN adds architectural hi_q/lo_q registers loaded on each response handshake.
module mult_arbiter #(
    parameter int MUL_LAT = 2   // multiplier settle cycles, legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_low,
    input  logic [31:0] mul_high,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_low,
    output logic [31:0] rsp_high,
    output logic        busy
`ifdef MULT_ARB_HILO_EN
    ,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    logic [3:0] counter;
    logic       rr_ptr;
    logic       owner;
    logic       grant;
    logic       accept;

    // rr_ptr only breaks ties; a lone requester always wins
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = rr_ptr;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= 4'd0;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            mul_a     <= 32'd0;
            mul_b     <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_low   <= 32'd0;
            rsp_high  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a   <= grant ? req1_a : req0_a;
                        mul_b   <= grant ? req1_b : req0_b;
                        owner   <= grant;
                        rr_ptr  <= ~grant;
                        counter <= 4'(MUL_LAT - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // operands have been stable for MUL_LAT cycles when counter reaches 0
                    if (counter == 4'd0) begin
                        rsp_low   <= mul_low;
                        rsp_high  <= mul_high;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_ARB_HILO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (rsp_valid && rsp_ready) begin
            hi_q <= rsp_high;
            lo_q <= rsp_low;
        end
    end
`endif

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Sequences and shares the single combinational 32x32 signed MULTIPLIER (outputs LOW/HIGH) between two requesters, e.g. the ALU issue path and a multi-cycle MUL/DIV helper.
- Latches operands, holds them stable on the multiplier inputs for a programmable settle time, captures the 64-bit product, and returns it with the requester id over a valid/ready handshake.
- Round-robin arbitration when both requesters are pending.

Parameters:
- MUL_LAT, 2: settle cycles allowed for the multiplier path; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  32  requester 0 operand A, signed
- req0_b  in  32  requester 0 operand B, signed
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1
- mul_a  out  32  to MULTIPLIER.A, registered
- mul_b  out  32  to MULTIPLIER.B, registered
- mul_low  in  32  from MULTIPLIER.LOW
- mul_high  in  32  from MULTIPLIER.HIGH
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  id of the requester that owns the result
- rsp_low  out  32  product bits [31:0]
- rsp_high  out  32  product bits [63:32]
- busy  out  1  state is not IDLE

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, rr_ptr=0, counter=0.
  - mul_a, mul_b, rsp_low, rsp_high and rsp_id are 0; rsp_valid=0; busy=0.
  - Both req*_ready are 0 while rst=1.
- States: IDLE, BUSY, DONE.
- IDLE, grant (combinational):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester equal to rr_ptr.
  - reqN_ready=1 only for the granted requester, and only in IDLE.
- Accept edge (valid & ready):
  - mul_a/mul_b <= granted operands; owner id <= grant; rr_ptr <= ~grant.
  - counter <= MUL_LAT-1; state -> BUSY.
- BUSY:
  - mul_a/mul_b are held; both readies are 0.
  - Each edge decrements counter.
  - On the edge where counter==0: rsp_low <= mul_low, rsp_high <= mul_high, rsp_id <= owner; rsp_valid <= 1; state -> DONE.
- Latency: rsp_valid rises exactly MUL_LAT edges after the accept edge.
- DONE:
  - Outputs are held until the edge with rsp_valid & rsp_ready; rsp_valid <= 0; state -> IDLE.
  - There is no accept on that same edge, so minimum issue interval is MUL_LAT+2 cycles.
- Idle outputs: mul_a/mul_b keep the last operands; rsp_low/rsp_high keep the last result.
- Arithmetic: no manipulation; the product is two's-complement signed, as produced by the multiplier.
- Requesters hold a/b stable while valid is high. The block samples operands only on the accept edge.
- A requester dropping valid before ready: no effect, no grant is recorded.
- Reset mid-operation (BUSY or DONE): operation discarded, no response issued, all state returns to reset values.
- busy=1 in BUSY and DONE.

Optional Feature:
- Macro: MULT_ARB_HILO_EN.
- Defined:
  - Adds ports hi_q out 32 and lo_q out 32 (architectural HI/LO registers).
  - Both reset to 0.
  - Both load rsp_high/rsp_low on every response handshake edge (rsp_valid & rsp_ready); otherwise they hold.
- Undefined: ports and registers are absent; all other behaviour is identical.

Test Plan:
- MUL_LAT=2, req0 A=0x00000002 B=0xFFFFFFFE -> rsp_valid 2 edges after accept; rsp_low=0xFFFFFFFC, rsp_high=0xFFFFFFFF, rsp_id=0.
- req1 A=0x00000005 B=0x00000006, rsp_ready held 0 for 5 cycles -> rsp_low=0x0000001E, rsp_high=0, rsp_id=1; outputs stable for all 5 cycles; busy=1 until the handshake.
- Both requesters valid continuously: req0 A=0xFFFFFFFB B=0x00000006; req1 A=0xFFFFFFFB B=0xFFFFFFFA.
  - Grants alternate 0,1,0,1.
  - req0 results: low=0xFFFFFFE2, high=0xFFFFFFFF.
  - req1 results: low=0x0000001E, high=0.
  - Issue interval is 4 cycles with rsp_ready=1.
- rst asserted in the BUSY cycle after accepting 2x2 -> no rsp_valid afterwards; mul_a=mul_b=0; rr_ptr=0, so the next simultaneous request is granted to req0.
- Sweep MUL_LAT=1 and 15 with 2x2 -> rsp_valid 1 and 15 edges after accept respectively; low=4, high=0.
- MULT_ARB_HILO_EN defined, run the 2x(-2) case -> hi_q/lo_q=0 before the handshake; hi_q=0xFFFFFFFF, lo_q=0xFFFFFFFC after it; values unchanged while idle.
